// File: rtl/stage_pkg.sv
// Shared types and sizing helpers for the fetch/decode stage register and its skid buffer.
package stage_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Default bubble instruction value (all zeros).
    localparam int unsigned NOP_DEFAULT = 0;

    // Width needed to hold a count of 0..depth.
    function automatic int unsigned skid_cnt_w(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

    // Pointer width; a single-entry buffer still needs one bit.
    function automatic int unsigned skid_ptr_w(input int unsigned depth);
        return (depth > 1) ? unsigned'($clog2(depth)) : 1;
    endfunction

    function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/stage_skid_fifo.sv
// Circular skid buffer that holds entries accepted while the output register is frozen.
module stage_skid_fifo
    import stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = skid_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = skid_ptr_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_data = mem[head_ptr];

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push)
            mem[tail_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)
                tail_ptr <= next_ptr(tail_ptr);
            if (pop)
                head_ptr <= next_ptr(head_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stage_reg.sv
// Pipeline stage register with freeze/flush and a skid buffer absorbing input during freeze.
// Optional STAGE_REG_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module stage_reg
    import stage_pkg::*;
#(
    parameter int unsigned          PC_W       = 32,
    parameter int unsigned          INSTR_W    = 32,
    parameter int unsigned          SKID_DEPTH = 2,
    parameter logic [INSTR_W-1:0]   NOP_INSTR  = INSTR_W'(NOP_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic               out_valid,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction
`ifdef STAGE_REG_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int unsigned CNT_W  = skid_cnt_w(SKID_DEPTH);
    localparam int unsigned DATA_W = PC_W + INSTR_W;

    logic              accept;
    logic              has_head;
    logic              push;
    logic              pop;
    logic              load_out;
    logic              nxt_valid;
    logic [PC_W-1:0]   nxt_pc;
    logic [INSTR_W-1:0] nxt_instr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  skid_count;
    occ_e              occ;

    stage_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .W     (DATA_W),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .push_data ({pc_in, instruction_in}),
        .head_data (head_data),
        .count     (skid_count)
    );

    assign occ      = occ_of(32'(skid_count), SKID_DEPTH);
    assign has_head = (occ != OCC_EMPTY);
    assign in_ready = !flush && (occ != OCC_FULL);
    assign accept   = in_valid && in_ready;

    // Output source select: skid head first, then bypassed input, else a bubble.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        load_out  = 1'b0;
        nxt_valid = 1'b0;
        nxt_pc    = '0;
        nxt_instr = NOP_INSTR;
        if (!flush) begin
            if (freeze) begin
                push = accept;
            end else begin
                load_out = 1'b1;
                if (has_head) begin
                    pop       = 1'b1;
                    push      = accept;
                    nxt_valid = 1'b1;
                    nxt_pc    = head_data[DATA_W-1:INSTR_W];
                    nxt_instr = head_data[INSTR_W-1:0];
                end else if (accept) begin
                    nxt_valid = 1'b1;
                    nxt_pc    = pc_in;
                    nxt_instr = instruction_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid   <= 1'b0;
            pc          <= '0;
            instruction <= NOP_INSTR;
        end else if (load_out) begin
            out_valid   <= nxt_valid;
            pc          <= nxt_pc;
            instruction <= nxt_instr;
        end
    end

`ifdef STAGE_REG_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze && out_valid && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
